// File: rtl/act_shift_add_mult.sv
// -----------------------------------------------------------------------------
// act_shift_add_mult
//
// Sequential unsigned N x N shift-add multiplier. Every internal register is a
// 4:1 mux-select cell (hold / load / shift-accumulate / sync clear) feeding a
// flip-flop. A three-process controller FSM drives the 2-bit select of each
// cell and produces a busy/done handshake toward the next stage.
//
// Ports:
//   CLK    rising-edge clock
//   CLRn   asynchronous active-low reset; aborts any operation in progress
//   start  multiply request, sampled only in IDLE
//   A      multiplicand (N bits, unsigned), captured in LOAD
//   B      multiplier (N bits, unsigned), captured in LOAD
//   busy   high in LOAD and CALC
//   done   one-cycle pulse in DONE
//   P      2N-bit product register, updated only at the edge entering DONE
// -----------------------------------------------------------------------------
module act_shift_add_mult #(
   parameter int unsigned N = 8
) (
   input  logic           CLK,
   input  logic           CLRn,
   input  logic           start,
   input  logic [N-1:0]   A,
   input  logic [N-1:0]   B,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] P
);

   localparam int unsigned CntW = $clog2(N);
   localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

   typedef enum logic [1:0] {
      StIdle,
      StLoad,
      StCalc,
      StDone
   } state_e;

   // Select encoding shared by every mux-select register cell.
   typedef enum logic [1:0] {
      ModeHold  = 2'b00,
      ModeLoad  = 2'b01,
      ModeShift = 2'b10,
      ModeClear = 2'b11
   } mode_e;

   state_e state_q, state_d;

   logic [N-1:0]    mc_q, mc_d;
   logic [N:0]      acc_q, acc_d;
   logic [N-1:0]    mq_q, mq_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2*N-1:0]  p_q, p_d;

   mode_e mc_mode, acc_mode, mq_mode, cnt_mode, p_mode;

   logic [N-1:0]   addend;
   logic [N:0]     sum;
   logic [N:0]     acc_shift;
   logic [N-1:0]   mq_shift;
   logic [2*N-1:0] prod_shift;
   logic           last_iter;

   // ---------------------------------------------------------------------------
   // Datapath: one shift-add iteration
   // ---------------------------------------------------------------------------
   assign last_iter = (cnt_q == CntLast);
   assign addend    = mq_q[0] ? mc_q : '0;
   // ACC[N] is always 0 at the start of an iteration (cleared in LOAD, shifted
   // in as 0), so adding the full ACC equals adding ACC[N-1:0].
   assign sum        = acc_q + {1'b0, addend};
   assign acc_shift  = {1'b0, sum[N:1]};
   assign mq_shift   = {sum[0], mq_q[N-1:1]};
   // Product as it appears after this iteration's shift: {ACC[N-1:0], MQ}.
   assign prod_shift = {sum, mq_q[N-1:1]};

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (start) state_d = StLoad;
         StLoad:  state_d = StCalc;
         StCalc:  if (last_iter) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs and register-cell selects
   // ---------------------------------------------------------------------------
   always_comb begin
      mc_mode  = ModeHold;
      acc_mode = ModeHold;
      mq_mode  = ModeHold;
      cnt_mode = ModeHold;
      p_mode   = ModeHold;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state_q)
         StIdle: begin
         end
         StLoad: begin
            mc_mode  = ModeLoad;
            mq_mode  = ModeLoad;
            acc_mode = ModeClear;
            cnt_mode = ModeClear;
            busy     = 1'b1;
         end
         StCalc: begin
            acc_mode = ModeShift;
            mq_mode  = ModeShift;
            cnt_mode = ModeShift;
            busy     = 1'b1;
            if (last_iter) p_mode = ModeLoad;
         end
         StDone: begin
            done = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Mux-select register cells. Inputs with no use in a given cell hold.
   // ---------------------------------------------------------------------------
   always_comb begin
      mc_d = mc_q;
      unique case (mc_mode)
         ModeHold:  mc_d = mc_q;
         ModeLoad:  mc_d = A;
         ModeShift: mc_d = mc_q;
         ModeClear: mc_d = '0;
         default:   mc_d = mc_q;
      endcase
   end

   always_comb begin
      acc_d = acc_q;
      unique case (acc_mode)
         ModeHold:  acc_d = acc_q;
         ModeLoad:  acc_d = acc_q;
         ModeShift: acc_d = acc_shift;
         ModeClear: acc_d = '0;
         default:   acc_d = acc_q;
      endcase
   end

   always_comb begin
      mq_d = mq_q;
      unique case (mq_mode)
         ModeHold:  mq_d = mq_q;
         ModeLoad:  mq_d = B;
         ModeShift: mq_d = mq_shift;
         ModeClear: mq_d = '0;
         default:   mq_d = mq_q;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      unique case (cnt_mode)
         ModeHold:  cnt_d = cnt_q;
         ModeLoad:  cnt_d = cnt_q;
         ModeShift: cnt_d = cnt_q + CntW'(1);
         ModeClear: cnt_d = '0;
         default:   cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      p_d = p_q;
      unique case (p_mode)
         ModeHold:  p_d = p_q;
         ModeLoad:  p_d = prod_shift;
         ModeShift: p_d = p_q;
         ModeClear: p_d = '0;
         default:   p_d = p_q;
      endcase
   end

   always_ff @(posedge CLK or negedge CLRn) begin
      if (!CLRn) begin
         mc_q  <= '0;
         acc_q <= '0;
         mq_q  <= '0;
         cnt_q <= '0;
         p_q   <= '0;
      end else begin
         mc_q  <= mc_d;
         acc_q <= acc_d;
         mq_q  <= mq_d;
         cnt_q <= cnt_d;
         p_q   <= p_d;
      end
   end

   assign P = p_q;

endmodule
